// File: rtl/router_sync13.sv
// router_sync13: address latch, write steering, full mux and per-port watchdog for a 1x3 router
//   clk, resetn (sync, active-low)
//   detect_add, data_in[1:0]         : header address capture
//   write_en_reg -> write_enb[2:0]    : one-hot write steering by latched address
//   full_0..2    -> fifo_full         : full flag of the addressed FIFO
//   empty_0..2   -> vld_out_0..2      : port has data
//   read_en_0..2                      : reads that keep the watchdogs quiet
//   soft_reset_0..2                   : one-cycle timeout pulse per port
module router_sync13 #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_en_reg,
  input  logic       read_en_0,
  input  logic       read_en_1,
  input  logic       read_en_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic       fifo_full,
  output logic [2:0] write_enb,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [1:0] addr_q, addr_d;
  logic [2:0] vld, rd, sr_q, sr_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0] oh, full_x;
  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd = {read_en_2, read_en_1, read_en_0};
  // address 11 shifts the one-hot into bit 3 and selects the tied-low full bit
  assign oh = 4'b0001 << addr_q;
  assign full_x = {1'b0, full_2, full_1, full_0};
  always_comb begin
    addr_d = detect_add ? data_in : addr_q;
    write_enb = write_en_reg ? oh[2:0] : 3'b000;
    fifo_full = full_x[addr_q];
    sr_d = '0;
    cnt_d = '0;
    for (int n = 0; n < 3; n++) begin
      sr_d[n] = vld[n] && !rd[n] && cnt_q[n] == LAST;
      cnt_d[n] = (!vld[n] || rd[n] || cnt_q[n] == LAST) ? '0 : cnt_q[n] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= 2'b11;
      cnt_q <= '0;
      sr_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
    end
  end
  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];
  assign soft_reset_0 = sr_q[0];
  assign soft_reset_1 = sr_q[1];
  assign soft_reset_2 = sr_q[2];
endmodule
